// File: rtl/smart_toilet_inlet_seq.sv
// Inlet valve sequencer for the smart_toilet mixing network: opens soln3, soln2 and soln1
// in turn, waits out the mix/transit interval, then hands the sample to the detector.
module smart_toilet_inlet_seq #(
  parameter int CNT_W = 16,
  parameter int RUN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] t_soln3,
  input  logic [CNT_W-1:0] t_soln2,
  input  logic [CNT_W-1:0] t_soln1,
  input  logic [CNT_W-1:0] t_mix,
  input  logic             sample_ready,
  output logic             valve_soln1,
  output logic             valve_soln2,
  output logic             valve_soln3,
  output logic             busy,
  output logic             sample_valid,
  output logic             done,
  output logic             aborted,
  output logic [RUN_W-1:0] run_count
);

  typedef enum logic [2:0] {IDLE, FILL3, FILL2, FILL1, MIX, READY} state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] t3_q, t2_q, t1_q, tm_q;
  logic [RUN_W-1:0] runCount_q;
  logic             done_q, aborted_q;

  state_e           advSt_d;
  logic [CNT_W-1:0] advCnt_d;
  logic [CNT_W-1:0] d3, d2, d1, dm;

  // Earliest timed state at or after 'from' whose duration is non-zero; READY if none.
  function automatic state_e firstFrom(input state_e from,
                                       input logic [CNT_W-1:0] f3, f2, f1, fm);
    state_e s;
    s = READY;
    if ((from inside {FILL3, FILL2, FILL1, MIX}) && (fm != '0)) s = MIX;
    if ((from inside {FILL3, FILL2, FILL1}) && (f1 != '0))      s = FILL1;
    if ((from inside {FILL3, FILL2}) && (f2 != '0))             s = FILL2;
    if ((from == FILL3) && (f3 != '0))                          s = FILL3;
    return s;
  endfunction

  function automatic state_e succOf(input state_e s);
    case (s)
      FILL3:   return FILL2;
      FILL2:   return FILL1;
      FILL1:   return MIX;
      default: return READY;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] durOf(input state_e s,
                                             input logic [CNT_W-1:0] f3, f2, f1, fm);
    case (s)
      FILL3:   return f3;
      FILL2:   return f2;
      FILL1:   return f1;
      MIX:     return fm;
      default: return '0;
    endcase
  endfunction

  // In IDLE the live inputs decide the first state; afterwards only the captured copies count.
  always_comb begin
    d3 = t3_q;
    d2 = t2_q;
    d1 = t1_q;
    dm = tm_q;
    advSt_d = READY;
    if (state_q == IDLE) begin
      d3 = t_soln3;
      d2 = t_soln2;
      d1 = t_soln1;
      dm = t_mix;
      advSt_d = firstFrom(FILL3, d3, d2, d1, dm);
    end else begin
      advSt_d = firstFrom(succOf(state_q), d3, d2, d1, dm);
    end
    advCnt_d = durOf(advSt_d, d3, d2, d1, dm);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      t3_q       <= '0;
      t2_q       <= '0;
      t1_q       <= '0;
      tm_q       <= '0;
      runCount_q <= '0;
      done_q     <= 1'b0;
      aborted_q  <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start && !abort) begin
            t3_q    <= t_soln3;
            t2_q    <= t_soln2;
            t1_q    <= t_soln1;
            tm_q    <= t_mix;
            state_q <= advSt_d;
            cnt_q   <= advCnt_d;
          end
        end
        FILL3, FILL2, FILL1, MIX: begin
          if (abort) begin
            state_q   <= IDLE;
            aborted_q <= 1'b1;
          end else if (cnt_q == CNT_W'(1)) begin
            state_q <= advSt_d;
            cnt_q   <= advCnt_d;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        READY: begin
          // Abort wins over a simultaneous handshake: no done, no count.
          if (abort) begin
            state_q   <= IDLE;
            aborted_q <= 1'b1;
          end else if (sample_ready) begin
            state_q    <= IDLE;
            done_q     <= 1'b1;
            runCount_q <= runCount_q + RUN_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign valve_soln3  = (state_q == FILL3);
  assign valve_soln2  = (state_q == FILL2);
  assign valve_soln1  = (state_q == FILL1);
  assign sample_valid = (state_q == READY);
  assign busy         = (state_q != IDLE);
  assign done         = done_q;
  assign aborted      = aborted_q;
  assign run_count    = runCount_q;

endmodule
